// File: rtl/code_sequencer_3b_if.sv
// rtl/code_sequencer_3b_if.sv - control and code bus between a sweep requester and code_sequencer_3b
interface code_sequencer_3b_if #(
    parameter int WIDTH   = 3,
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               dir;
    logic [DWELL_W-1:0] dwell;
    logic [WIDTH-1:0]   code_o;
    logic               code_valid;
    logic               busy;
    logic               done;

    // Requester side: issues sweep requests, observes the generated code
    modport master (
        output start, stop, dir, dwell,
        input  code_o, code_valid, busy, done
    );

    // Sequencer side
    modport slave (
        input  start, stop, dir, dwell,
        output code_o, code_valid, busy, done
    );
endinterface

// File: rtl/code_sequencer_3b.sv
// rtl/code_sequencer_3b.sv - code sweep source with per-code dwell; optional wrap mode under SEQ_LOOP_EN
module code_sequencer_3b #(
    parameter int WIDTH   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    code_sequencer_3b_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   CODE_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   CODE_MIN = '0;
    localparam logic [DWELL_W-1:0] ONE_D    = DWELL_W'(1);

    state_t             state;
    logic [WIDTH-1:0]   code_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] dwell_l;
    logic               dir_l;

    logic [DWELL_W-1:0] dwell_eff;
    logic [WIDTH-1:0]   end_code;
    logic [WIDTH-1:0]   start_code;
    logic [WIDTH-1:0]   next_code;

    // A zero dwell would never let a code be seen, so it is promoted to one cycle
    always_comb begin
        dwell_eff  = (bus.dwell == '0) ? ONE_D : bus.dwell;
        end_code   = dir_l ? CODE_MIN : CODE_MAX;
        start_code = dir_l ? CODE_MAX : CODE_MIN;
        next_code  = dir_l ? (code_q - WIDTH'(1)) : (code_q + WIDTH'(1));
    end

    // Sweep state machine; every output comes straight from a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            dwell_l <= '0;
            dir_l   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    // stop has priority so a simultaneous abort never launches a sweep
                    if (bus.start && !bus.stop) begin
                        dir_l   <= bus.dir;
                        dwell_l <= dwell_eff;
                        code_q  <= bus.dir ? CODE_MAX : CODE_MIN;
                        cnt_q   <= dwell_eff - ONE_D;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    done_q <= 1'b0;
                    if (bus.stop) begin
                        // Abort: code_o freezes where it was, no completion pulse
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - ONE_D;
                    end else if (code_q == end_code) begin
`ifdef SEQ_LOOP_EN
                        code_q <= start_code;
                        cnt_q  <= dwell_l - ONE_D;
                        done_q <= 1'b1;
`else
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
`endif
                    end else begin
                        code_q <= next_code;
                        cnt_q  <= dwell_l - ONE_D;
                    end
                end
                DONE: begin
                    // One-cycle completion pulse; a new sweep must be requested from IDLE
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.code_o     = code_q;
    assign bus.code_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    logic unused_start_code;
    assign unused_start_code = ^start_code;
endmodule

// File: tb/tb_code_sequencer_3b.sv
// tb/tb_code_sequencer_3b.sv - directed self-checking bench for code_sequencer_3b
`timescale 1ns/1ps
module tb_code_sequencer_3b;
    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    code_sequencer_3b_if #(.WIDTH(3), .DWELL_W(8)) bus ();

    code_sequencer_3b #(.WIDTH(3), .DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input int code, input bit valid, input bit busy, input bit done);
        chk({tag, ".code"},  32'(bus.code_o),     32'(code));
        chk({tag, ".valid"}, 32'(bus.code_valid), 32'(valid));
        chk({tag, ".busy"},  32'(bus.busy),       32'(busy));
        chk({tag, ".done"},  32'(bus.done),       32'(done));
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.dir   = 1'b0;
        bus.dwell = 8'd0;

        #1;
        outs("reset", 0, 0, 0, 0);
        #12;
        rst_n = 1'b1;
        tick();
        outs("idle", 0, 0, 0, 0);

`ifndef SEQ_LOOP_EN
        // dwell=100 up sweep: each code held 100 cycles, done at E0+800
        bus.dwell = 8'd100; bus.dir = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        outs("t1.e0", 0, 1, 1, 0);
        for (int k = 1; k < 800; k++) begin
            tick();
            chk("t1.code", 32'(bus.code_o), 32'(k / 100));
            chk("t1.done", 32'(bus.done), 32'(0));
        end
        tick();
        outs("t1.end", 7, 0, 0, 1);
        tick();
        outs("t1.after", 7, 0, 0, 0);

        // dwell=0 behaves as 1
        bus.dwell = 8'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        outs("t2.e0", 0, 1, 1, 0);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("t2.code", 32'(bus.code_o), 32'(k));
        end
        tick();
        outs("t2.end", 7, 0, 0, 1);

        // dwell=2 down sweep: 7,7,6,6,..,0,0
        tick();
        bus.dwell = 8'd2; bus.dir = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        outs("t3.e0", 7, 1, 1, 0);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("t3.code", 32'(bus.code_o), 32'(7 - k / 2));
        end
        tick();
        outs("t3.end", 0, 0, 0, 1);
        tick();
        outs("t3.hold", 0, 0, 0, 0);
`else
        // wrap mode, dwell=1: done pulses at E0+8 and E0+16, busy held
        bus.dwell = 8'd1; bus.dir = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        outs("t6.e0", 0, 1, 1, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("t6.code", 32'(bus.code_o), 32'(k % 8));
            chk("t6.done", 32'(bus.done), 32'((k % 8) == 0));
            chk("t6.busy", 32'(bus.busy), 32'(1));
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        outs("t6.stop", 0, 0, 0, 0);
        bus.dir = 1'b0;
`endif

        // stop while code_o=3 with dwell=4
        tick();
        bus.dwell = 8'd4; bus.dir = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (12) tick();
        outs("t4.pre", 3, 1, 1, 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        outs("t4.stop", 3, 0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("t4.nodone", 32'(bus.done), 32'(0));
        end
        chk("t4.code", 32'(bus.code_o), 32'(3));

        // start/dir/dwell changes during RUN are ignored, then async reset mid-sweep
        bus.dwell = 8'd4; bus.dir = 1'b0; bus.start = 1'b1;
        tick();
        bus.dir = 1'b1; bus.dwell = 8'd1;
        tick();
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        outs("t5.latched", 1, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        outs("t5.async", 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        outs("t5.stopwins", 0, 0, 0, 0);
        bus.start = 1'b0; bus.stop = 1'b0;
        tick();
        outs("t5.idle", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
